ppi_bus_sequencer: RTL and testbench



---
 rtl/ppi_pkg.sv | 27 ++
 rtl/ppi_rr_arb2.sv | 42 ++++
 rtl/ppi_bus_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_ppi_bus_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_pkg
//  Description : Shared definitions for the PPI bus sequencer: port-select
//                encodings, sequencer FSM state type and phase-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package ppi_pkg;

    // Width of the per-phase down-counter (phase lengths 1..15)
    localparam int PPI_PHASE_W = 4;

    // PPI PortSelect encodings
    localparam logic [1:0] PPI_PORT_A    = 2'd0;
    localparam logic [1:0] PPI_PORT_B    = 2'd1;
    localparam logic [1:0] PPI_PORT_C    = 2'd2;
    localparam logic [1:0] PPI_PORT_CTRL = 2'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_SETUP  = 2'd1,
        SEQ_STROBE = 2'd2,
        SEQ_HOLD   = 2'd3
    } ppi_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ppi_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_rr_arb2
//  Description : Two-way round-robin arbiter. A lone requester always wins;
//                on contention the pointer decides. The pointer moves to the
//                non-granted requester whenever a grant is consumed.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_valid[1:0]   - request lines
//                i_advance      - current grant was accepted this cycle
//                o_grant[1:0]   - one-hot (or zero) combinational grant
//  Revision    : 1.0  initial release
// ============================================================================
module ppi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // 0: requester 0 has priority, 1: requester 1 has priority
    logic r_ptr;

    always_comb begin
        if (i_valid == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            // granting requester 0 hands priority to requester 1 and vice versa
            r_ptr <= o_grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_bus_sequencer
//  Description : Clocked front-end for the PPI strobe interface. Arbitrates
//                two single-byte requesters round-robin and runs each request
//                as a SETUP / STROBE / HOLD bus cycle with registered strobes.
//                Generates the PPI reset pulse and returns completions.
//  Ports       : Clk, Reset                 - clock, sync active-high reset
//                reqN_valid/ready/we/sel/wdata - requester N handshake
//                rsp_valid/id/rdata         - completion pulse
//                ppi_cs_n/rd_n/wr_n/sel     - PPI control pins (registered)
//                ppi_dout/doe, ppi_din      - DATA drive value/enable, pin value
//                ppi_rst                    - PPI reset (registered)
//                ctrl_shadow                - control shadow (option only)
//  Option      : PPI_CTRL_SHADOW_EN - control-register shadow; control reads
//                are answered from the shadow without a bus cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RST_CYC    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
`ifdef PPI_CTRL_SHADOW_EN
    output logic [7:0] ctrl_shadow,
`endif
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_we,
    input  logic [1:0] req0_sel,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_we,
    input  logic [1:0] req1_sel,
    input  logic [7:0] req1_wdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       ppi_cs_n,
    output logic       ppi_rd_n,
    output logic       ppi_wr_n,
    output logic [1:0] ppi_sel,
    output logic [7:0] ppi_dout,
    output logic       ppi_doe,
    input  logic [7:0] ppi_din,
    output logic       ppi_rst
);

    localparam logic [PPI_PHASE_W-1:0] c_SETUP_LD  = PPI_PHASE_W'(SETUP_CYC - 1);
    localparam logic [PPI_PHASE_W-1:0] c_STROBE_LD = PPI_PHASE_W'(STROBE_CYC - 1);
    localparam logic [PPI_PHASE_W-1:0] c_HOLD_LD   = PPI_PHASE_W'(HOLD_CYC - 1);
    localparam logic [PPI_PHASE_W-1:0] c_RST_LD    = PPI_PHASE_W'(RST_CYC);

    ppi_seq_state_t         r_state, w_state_nxt;
    logic [PPI_PHASE_W-1:0] r_cnt, w_cnt_nxt;
    logic [PPI_PHASE_W-1:0] r_rst_cnt;

    logic       r_we, r_id;
    logic [1:0] r_sel;
    logic [7:0] r_wdata, r_sample;

    logic [1:0] w_grant;
    logic       w_accept, w_acc_id, w_acc_we, w_bypass, w_sample_en;
    logic [1:0] w_acc_sel;
    logic [7:0] w_acc_wdata;
    logic       w_we_nxt, w_busy_nxt;
    logic [1:0] w_sel_nxt;
    logic [7:0] w_wdata_nxt;
    logic       w_rsp_valid_nxt, w_rsp_id_nxt;
    logic [7:0] w_rsp_rdata_nxt;

    ppi_rr_arb2 u_arb (
        .clk       (Clk),
        .rst       (Reset),
        .i_valid   ({req1_valid, req0_valid}),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Grants are only offered while idle and out of PPI reset
    assign req0_ready  = (r_state == SEQ_IDLE) && !ppi_rst && w_grant[0];
    assign req1_ready  = (r_state == SEQ_IDLE) && !ppi_rst && w_grant[1];
    assign w_accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_acc_id    = w_grant[1];
    assign w_acc_we    = w_acc_id ? req1_we    : req0_we;
    assign w_acc_sel   = w_acc_id ? req1_sel   : req0_sel;
    assign w_acc_wdata = w_acc_id ? req1_wdata : req0_wdata;

`ifdef PPI_CTRL_SHADOW_EN
    logic [7:0] r_shadow;

    assign w_bypass    = w_accept && !w_acc_we && (w_acc_sel == PPI_PORT_CTRL);
    assign ctrl_shadow = r_shadow;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shadow <= 8'h00;
        end else if (w_accept && w_acc_we && (w_acc_sel == PPI_PORT_CTRL)) begin
            r_shadow <= w_acc_wdata;
        end
    end
`else
    assign w_bypass = 1'b0;
`endif

    // Next-state, phase counter and completion
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sample_en     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_id_nxt    = rsp_id;
        w_rsp_rdata_nxt = rsp_rdata;
        case (r_state)
            SEQ_IDLE: begin
                if (w_bypass) begin
`ifdef PPI_CTRL_SHADOW_EN
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = w_acc_id;
                    w_rsp_rdata_nxt = r_shadow;
`endif
                end else if (w_accept) begin
                    w_state_nxt = SEQ_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            SEQ_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SEQ_STROBE;
                    w_cnt_nxt   = c_STROBE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            SEQ_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SEQ_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                    w_sample_en = 1'b1;   // DATA captured on the last strobe cycle
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            SEQ_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = SEQ_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_rdata_nxt = r_we ? 8'h00 : r_sample;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase

        // Pins are computed from the next state so they can be registered
        // and still line up with the phase they belong to.
        w_we_nxt    = w_accept ? w_acc_we    : r_we;
        w_sel_nxt   = w_accept ? w_acc_sel   : r_sel;
        w_wdata_nxt = w_accept ? w_acc_wdata : r_wdata;
        w_busy_nxt  = (w_state_nxt != SEQ_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= SEQ_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we      <= 1'b0;
            r_id      <= 1'b0;
            r_sel     <= 2'd0;
            r_wdata   <= 8'h00;
            r_sample  <= 8'h00;
            r_rst_cnt <= c_RST_LD;
            ppi_rst   <= 1'b1;
            ppi_cs_n  <= 1'b1;
            ppi_rd_n  <= 1'b1;
            ppi_wr_n  <= 1'b1;
            ppi_sel   <= 2'd0;
            ppi_dout  <= 8'h00;
            ppi_doe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            if (w_accept) begin
                r_we    <= w_acc_we;
                r_id    <= w_acc_id;
                r_sel   <= w_acc_sel;
                r_wdata <= w_acc_wdata;
            end
            if (w_sample_en) begin
                r_sample <= ppi_din;
            end
            // PPI reset stays high for RST_CYC cycles after Reset falls
            ppi_rst <= (r_rst_cnt != '0);
            if (r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end
            ppi_cs_n  <= !w_busy_nxt;
            ppi_rd_n  <= !((w_state_nxt == SEQ_STROBE) && !w_we_nxt);
            ppi_wr_n  <= !((w_state_nxt == SEQ_STROBE) &&  w_we_nxt);
            ppi_sel   <= w_busy_nxt ? w_sel_nxt : 2'd0;
            ppi_doe   <= w_busy_nxt && w_we_nxt;
            ppi_dout  <= (w_busy_nxt && w_we_nxt) ? w_wdata_nxt : 8'h00;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_id    <= w_rsp_id_nxt;
            rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppi_bus_sequencer
//  Description : Directed self-checking bench for ppi_bus_sequencer. One
//                instance with default timing, a second with SETUP=3,
//                STROBE=1, HOLD=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ppi_bus_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [1:0] req0_sel, req1_sel;
    logic [7:0] req0_wdata, req1_wdata;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_rdata;
    logic       ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_doe, ppi_rst;
    logic [1:0] ppi_sel;
    logic [7:0] ppi_dout, ppi_din;
`ifdef PPI_CTRL_SHADOW_EN
    logic [7:0] ctrl_shadow, b_ctrl_shadow;
`endif

    // second instance signals
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic       b_rsp_valid, b_rsp_id;
    logic [7:0] b_rsp_rdata, b_dout, b_din;
    logic       b_cs_n, b_rd_n, b_wr_n, b_doe, b_rst;
    logic [1:0] b_sel;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ppi_bus_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
`ifdef PPI_CTRL_SHADOW_EN
        .ctrl_shadow(ctrl_shadow),
`endif
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_sel   (req0_sel),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_sel   (req1_sel),
        .req1_wdata (req1_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .ppi_cs_n   (ppi_cs_n),
        .ppi_rd_n   (ppi_rd_n),
        .ppi_wr_n   (ppi_wr_n),
        .ppi_sel    (ppi_sel),
        .ppi_dout   (ppi_dout),
        .ppi_doe    (ppi_doe),
        .ppi_din    (ppi_din),
        .ppi_rst    (ppi_rst)
    );

    ppi_bus_sequencer #(
        .SETUP_CYC (3),
        .STROBE_CYC(1),
        .HOLD_CYC  (2),
        .RST_CYC   (4)
    ) dut2 (
        .Clk        (Clk),
        .Reset      (Reset),
`ifdef PPI_CTRL_SHADOW_EN
        .ctrl_shadow(b_ctrl_shadow),
`endif
        .req0_valid (b_req0_valid),
        .req0_ready (b_req0_ready),
        .req0_we    (1'b0),
        .req0_sel   (2'd2),
        .req0_wdata (8'h00),
        .req1_valid (b_req1_valid),
        .req1_ready (b_req1_ready),
        .req1_we    (1'b0),
        .req1_sel   (2'd0),
        .req1_wdata (8'h00),
        .rsp_valid  (b_rsp_valid),
        .rsp_id     (b_rsp_id),
        .rsp_rdata  (b_rsp_rdata),
        .ppi_cs_n   (b_cs_n),
        .ppi_rd_n   (b_rd_n),
        .ppi_wr_n   (b_wr_n),
        .ppi_sel    (b_sel),
        .ppi_dout   (b_dout),
        .ppi_doe    (b_doe),
        .ppi_din    (b_din),
        .ppi_rst    (b_rst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        Reset        = 1'b1;
        req0_valid   = 1'b1;  req0_we = 1'b1; req0_sel = 2'd0; req0_wdata = 8'hA5;
        req1_valid   = 1'b0;  req1_we = 1'b0; req1_sel = 2'd0; req1_wdata = 8'h00;
        ppi_din      = 8'h00;
        b_req0_valid = 1'b0;  b_req1_valid = 1'b0; b_din = 8'h4D;

        // ---------------- reset values and PPI reset pulse ----------------
        tick();
        chk("rst_cs_n", ppi_cs_n, 1);   chk("rst_rd_n", ppi_rd_n, 1);
        chk("rst_wr_n", ppi_wr_n, 1);   chk("rst_sel", ppi_sel, 0);
        chk("rst_dout", ppi_dout, 0);   chk("rst_doe", ppi_doe, 0);
        chk("rst_rspv", rsp_valid, 0);  chk("rst_rspid", rsp_id, 0);
        chk("rst_rdata", rsp_rdata, 0); chk("rst_ppirst", ppi_rst, 1);
        chk("rst_rdy0", req0_ready, 0); chk("rst_rdy1", req1_ready, 0);
        tick();
        tick();
        Reset = 1'b0;
        n = 3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ppi_rst !== 1'b1) break;
            n++;
            chk("rdy_in_ppirst", req0_ready, 0);
        end
        chk("ppirst_len", n, 7);

        // ---------------- req0 write, port A, 0xA5 ----------------
        chk("w_rdy0", req0_ready, 1);
        chk("w_rdy1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req0_wdata = 8'h00;   // must be ignored after acceptance
        for (int i = 1; i <= 5; i++) begin
            chk("w_cs_n", ppi_cs_n, (i == 5));
            chk("w_wr_n", ppi_wr_n, !(i == 2 || i == 3));
            chk("w_rd_n", ppi_rd_n, 1);
            chk("w_doe", ppi_doe, (i < 5));
            if (i < 5) begin
                chk("w_dout", ppi_dout, 8'hA5);
                chk("w_sel", ppi_sel, 0);
            end
            chk("w_rspv", rsp_valid, (i == 5));
            if (i < 5) tick();
        end
        chk("w_rspid", rsp_id, 0);
        chk("w_rdata", rsp_rdata, 8'h00);

        // ---------------- req1 read, port B, DATA 0x99 on last strobe ----------------
        req1_valid = 1'b1; req1_we = 1'b0; req1_sel = 2'd1;
        #1;
        chk("r_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("r_cs_n", ppi_cs_n, (i == 5));
            chk("r_rd_n", ppi_rd_n, !(i == 2 || i == 3));
            chk("r_wr_n", ppi_wr_n, 1);
            chk("r_doe", ppi_doe, 0);
            if (i < 5) chk("r_sel", ppi_sel, 1);
            chk("r_rspv", rsp_valid, (i == 5));
            if (i == 2) ppi_din = 8'h22;
            if (i == 3) ppi_din = 8'h99;
            if (i == 4) ppi_din = 8'h11;
            if (i < 5) tick();
        end
        chk("r_rspid", rsp_id, 1);
        chk("r_rdata", rsp_rdata, 8'h99);

        // ---------------- contention: both valid, alternating grants ----------------
        req0_valid = 1'b1; req0_we = 1'b1; req0_sel = 2'd2; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_we = 1'b1; req1_sel = 2'd3; req1_wdata = 8'h22;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("rr_rdy0", req0_ready, (c % 10 == 0));
            chk("rr_rdy1", req1_ready, (c % 10 == 5));
            chk("rr_cs_n", ppi_cs_n, (c % 5 == 0));
            chk("rr_rspv", rsp_valid, (c % 5 == 0));
            if (c % 5 == 0) chk("rr_rspid", rsp_id, (c % 10 == 0));
            tick();
        end
        req1_valid = 1'b0;
        chk("rr_last_rspv", rsp_valid, 1);
        chk("rr_last_rspid", rsp_id, 1);

        // ---------------- reset during STROBE of a write ----------------
        req0_we = 1'b1; req0_sel = 2'd0; req0_wdata = 8'h5A;
        #1;
        chk("mr_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("mr_strobe", ppi_wr_n, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mr_wr_n", ppi_wr_n, 1);  chk("mr_cs_n", ppi_cs_n, 1);
        chk("mr_doe", ppi_doe, 0);    chk("mr_ppirst", ppi_rst, 1);
        chk("mr_rspv", rsp_valid, 0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("mr_no_rsp", rsp_valid, 0);
            if (ppi_rst !== 1'b1) break;
            n++;
        end
        chk("mr_ppirst_len", n, 4);

        // ---------------- control write then control read ----------------
        req0_valid = 1'b1; req0_we = 1'b1; req0_sel = 2'd3; req0_wdata = 8'h80;
        #1;
        chk("cw_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        repeat (4) tick();
        chk("cw_rspv", rsp_valid, 1);
        chk("cw_rspid", rsp_id, 0);
        ppi_din    = 8'h3C;
        req1_valid = 1'b1; req1_we = 1'b0; req1_sel = 2'd3;
        #1;
        chk("cr_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
`ifdef PPI_CTRL_SHADOW_EN
        chk("cr_rspv", rsp_valid, 1);
        chk("cr_rspid", rsp_id, 1);
        chk("cr_rdata", rsp_rdata, 8'h80);
        chk("cr_shadow", ctrl_shadow, 8'h80);
        for (int i = 1; i <= 4; i++) begin
            chk("cr_cs_idle", ppi_cs_n, 1);
            tick();
        end
`else
        for (int i = 1; i <= 5; i++) begin
            chk("cr_cs_n", ppi_cs_n, (i == 5));
            chk("cr_rd_n", ppi_rd_n, !(i == 2 || i == 3));
            chk("cr_rspv", rsp_valid, (i == 5));
            if (i < 5) tick();
        end
        chk("cr_rspid", rsp_id, 1);
        chk("cr_rdata", rsp_rdata, 8'h3C);
`endif

        // ---------------- alternate timing: SETUP=3 STROBE=1 HOLD=2 read ----------------
        b_req0_valid = 1'b1;
        #1;
        chk("b_rdy0", b_req0_ready, 1);
        tick();
        b_req0_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            chk("b_cs_n", b_cs_n, (i == 7));
            chk("b_rd_n", b_rd_n, !(i == 4));
            chk("b_wr_n", b_wr_n, 1);
            chk("b_rspv", b_rsp_valid, (i == 7));
            if (i < 7) begin
                chk("b_sel", b_sel, 2);
                tick();
            end
        end
        chk("b_rspid", b_rsp_id, 0);
        chk("b_rdata", b_rsp_rdata, 8'h4D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
